// File: rtl/ram_bank.sv
// ram_bank: register-based 1W/1R word memory with registered reads, write-first bypass and
// a clear sweep after reset or clr. Optional stored even parity under RAM_BANK_PARITY_EN.
`default_nettype none

module ram_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
`ifdef RAM_BANK_PARITY_EN
  input  logic             wr_par_flip,
  output logic             rd_par_err,
`endif
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

`ifdef RAM_BANK_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   ptr, ptr_nx;
  logic [MW-1:0]   mem [DEPTH];

  logic            wr_in, rd_in;
  logic            wr_fire, rd_fire, bypass;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [MW-1:0]   mem_data;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   rd_word;
  logic [WIDTH-1:0] rd_data_nx;

  assign wr_in   = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in   = ({1'b0, rd_addr} < DEPTH_X);

  // clr takes priority over any access presented in the same cycle
  assign wr_fire = (state == READY) && wr_en && !clr && wr_in;
  assign rd_fire = (state == READY) && rd_en && !clr;
  assign bypass  = wr_fire && rd_in && (wr_addr == rd_addr);

`ifdef RAM_BANK_PARITY_EN
  assign wr_word = {(^wr_data) ^ wr_par_flip, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    busy     = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr) begin
          ptr_nx = '0;
        end else if (ptr == PTR_LAST) begin
          state_nx = READY;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        ptr_nx   = '0;
      end
    endcase
  end

  // Single write port shared by the sweep and functional writes
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_word;
    if (busy) begin
      mem_we   = 1'b1;
      mem_addr = ptr;
      mem_data = '0;
    end else if (wr_fire) begin
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  assign rd_word    = rd_in ? mem[rd_addr] : '0;
  assign rd_data_nx = bypass ? wr_data : rd_word[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
`ifdef RAM_BANK_PARITY_EN
      rd_par_err <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data    <= rd_data_nx;
`ifdef RAM_BANK_PARITY_EN
        // Out-of-range words read as all-zero, whose parity is clean
        rd_par_err <= bypass ? wr_par_flip : (^rd_word);
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_bank.sv
// tb_ram_bank: scoreboard bench for ram_bank (DEPTH=6 main instance, DEPTH=8 for sweep length).
`default_nettype none

module tb_ram_bank;

  localparam int D = 6;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [15:0] rd_data8;
  logic        rd_valid8;
  logic        busy8;
`ifdef RAM_BANK_PARITY_EN
  logic        wr_par_flip;
  logic        rd_par_err;
  logic        rd_par_err8;
`endif

  int          n_checks;
  int          n_fail;
  logic [15:0] model [0:D-1];
  logic [15:0] sb_q [$];

  ram_bank #(.WIDTH(16), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_BANK_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(rd_par_err),
`endif
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  ram_bank #(.WIDTH(16), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .wr_en(1'b0), .wr_addr(3'd0), .wr_data(16'h0000),
    .rd_en(1'b0), .rd_addr(3'd0),
`ifdef RAM_BANK_PARITY_EN
    .wr_par_flip(1'b0), .rd_par_err(rd_par_err8),
`endif
    .rd_data(rd_data8), .rd_valid(rd_valid8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sb_pop();
    if (sb_q.size() == 0) return 16'hxxxx;
    return sb_q.pop_front();
  endfunction

  // Drives one cycle of access; expected read results come from the bench model.
  task automatic issue(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    if (re) begin
      if (ra >= 3'(D))                sb_q.push_back(16'h0000);
      else if (we && wa == ra)        sb_q.push_back(wd);
      else                            sb_q.push_back(model[ra]);
    end
    if (we && wa < 3'(D)) model[wa] = wd;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int c6, c8;
    logic [15:0] exp;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'h0000 || busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b v=%b d=%h busy8=%b want 1 0 0000 1",
               busy, rd_valid, rd_data, busy8);
    end
    rst_n = 1'b1;
    c6 = 0; c8 = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) c6++;
      if (busy8 === 1'b1) c8++;
      tick();
    end
    n_checks++;
    if (c6 != D) begin
      n_fail++; $display("FAIL sweep_len6: got %0d want %0d", c6, D);
    end
    n_checks++;
    if (c8 != 8) begin
      n_fail++; $display("FAIL sweep_len8: got %0d want 8", c8);
    end
    for (int a = 0; a < D; a++) begin
      issue(1'b0, 3'd0, 16'h0, 1'b1, 3'(a));
      exp = sb_pop();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++;
        $display("FAIL reset_rd%0d: got v=%b d=%h want v=1 d=%h", a, rd_valid, rd_data, exp);
      end
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%b d=%h want v=0 d=0000", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] exp;
    issue(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    for (int a = 0; a < D; a++) begin
      issue(1'b0, 3'd0, 16'h0, 1'b1, 3'((a + 3) % D));
      exp = sb_pop();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++;
        $display("FAIL wr_rd%0d: got v=%b d=%h want v=1 d=%h", (a + 3) % D, rd_valid, rd_data, exp);
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    issue(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0);
    issue(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5);
    exp = sb_pop();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL bypass_same: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
    issue(1'b1, 3'd1, 16'h5555, 1'b1, 3'd5);
    exp = sb_pop();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL bypass_diff: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
    exp = sb_pop();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL bypass_other: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp;
    issue(1'b1, 3'd6, 16'h7777, 1'b0, 3'd0);
    issue(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0);
    for (int a = 0; a < 8; a++) begin
      issue(1'b0, 3'd0, 16'h0, 1'b1, 3'(a));
      exp = sb_pop();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++;
        $display("FAIL oor_rd%0d: got v=%b d=%h want v=1 d=%h", a, rd_valid, rd_data, exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [15:0] exp;
    int c6, c8;
    for (int a = 0; a < D; a++) issue(1'b1, 3'(a), 16'hFFFF, 1'b0, 3'd0);
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    exp = sb_pop();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL fill_rd: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
    // clr together with a read and write: both dropped
    clr = 1'b1; rd_en = 1'b1; rd_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h9999;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < D; i++) begin
      n_checks++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL clr_sweep%0d: got busy=%b v=%b d=%h want 1 0 ffff", i, busy, rd_valid, rd_data);
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_end: got busy=%b v=%b want 0 0", busy, rd_valid);
    end
    rd_en = 1'b0;
    for (int a = 0; a < D; a++) model[a] = 16'h0000;
    for (int a = 0; a < D; a++) begin
      issue(1'b0, 3'd0, 16'h0, 1'b1, 3'(a));
      exp = sb_pop();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        n_fail++;
        $display("FAIL clr_rd%0d: got v=%b d=%h want v=1 d=%h", a, rd_valid, rd_data, exp);
      end
    end
    // reset in the middle of a sweep restarts it at full length
    issue(1'b1, 3'd1, 16'h4242, 1'b0, 3'd0);
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
    exp = sb_pop();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || rd_data !== 16'h0000 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b v=%b d=%h want 1 0 0000 (was %h)", busy, rd_valid, rd_data, exp);
    end
    tick();
    rst_n = 1'b1;
    c6 = 0; c8 = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) c6++;
      if (busy8 === 1'b1) c8++;
      tick();
    end
    n_checks++;
    if (c6 != D || c8 != 8) begin
      n_fail++;
      $display("FAIL mid_reset_len: got %0d/%0d want %0d/8", c6, c8, D);
    end
    for (int a = 0; a < D; a++) model[a] = 16'h0000;
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
    exp = sb_pop();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_rd: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp);
    end
  endtask

`ifdef RAM_BANK_PARITY_EN
  task automatic test_parity();
    logic [15:0] exp;
    wr_par_flip = 1'b1;
    issue(1'b1, 3'd2, 16'h0003, 1'b0, 3'd0);
    wr_par_flip = 1'b0;
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    exp = sb_pop();
    n_checks++;
    if (rd_data !== exp || rd_par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_flip: got d=%h err=%b want d=%h err=1", rd_data, rd_par_err, exp);
    end
    issue(1'b1, 3'd2, 16'h0003, 1'b0, 3'd0);
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    exp = sb_pop();
    n_checks++;
    if (rd_data !== exp || rd_par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clean: got d=%h err=%b want d=%h err=0", rd_data, rd_par_err, exp);
    end
    wr_par_flip = 1'b1;
    issue(1'b1, 3'd4, 16'h0107, 1'b1, 3'd4);
    wr_par_flip = 1'b0;
    exp = sb_pop();
    n_checks++;
    if (rd_data !== exp || rd_par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_bypass: got d=%h err=%b want d=%h err=1", rd_data, rd_par_err, exp);
    end
    issue(1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
    exp = sb_pop();
    n_checks++;
    if (rd_data !== exp || rd_par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_oor: got d=%h err=%b want d=%h err=0", rd_data, rd_par_err, exp);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
`ifdef RAM_BANK_PARITY_EN
    wr_par_flip = 1'b0;
`endif
    for (int a = 0; a < D; a++) model[a] = 16'h0000;
    test_reset();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_clear();
`ifdef RAM_BANK_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ram_bank.md
Name: ram_bank

Overview:
Parametrised single-clock, two-port (1 write, 1 read) word memory built from registers. It is the successor of the 16-bit load/address RAM: width and depth are generic, reads are registered with a valid flag, and same-address read-during-write is bypassed. A hardware clear sequencer zeroes every word after reset or on command. It serves as the data/register store for the CPU and memory-mapped blocks.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of words (>=2, need not be a power of two)
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  pulse: restart the clear sweep
wr_en  input  1  write strobe
wr_addr  input  AW  write address
wr_data  input  WIDTH  write data
rd_en  input  1  read strobe
rd_addr  input  AW  read address
rd_data  output  WIDTH  registered read data
rd_valid  output  1  rd_data updated this cycle
busy  output  1  clear sweep in progress; accesses ignored

Behaviour:
- Reset (rst_n low, async): state=CLEAR, sweep pointer=0, rd_data=0, rd_valid=0, busy=1. Array contents are not reset directly; the sweep zeroes them.
- FSM states: CLEAR, READY.
- CLEAR: each cycle write 0 to word[ptr], ptr++. At the cycle ptr==DEPTH-1 is written, go to READY the next edge. Sweep takes exactly DEPTH cycles after rst_n rises; busy drops in cycle DEPTH.
- READY: clr=1 -> CLEAR, ptr=0. clr in CLEAR restarts the sweep from 0. Reset mid-sweep restarts from 0.
- busy = (state==CLEAR). While busy: wr_en and rd_en ignored, rd_valid=0, rd_data holds.
- Write (READY, wr_en, wr_addr<DEPTH): word[wr_addr]<=wr_data at the edge. wr_addr>=DEPTH: dropped, no side effect.
- Read (READY, rd_en): 1-cycle latency; next edge rd_data<=word[rd_addr], rd_valid<=1. rd_en=0 -> rd_valid<=0, rd_data holds last value.
- rd_addr>=DEPTH: rd_data<=0, rd_valid<=1.
- Read-during-write, same address, same cycle: write-first, rd_data returns the new wr_data. Different addresses: independent.
- clr and wr_en/rd_en in the same READY cycle: clr wins; access dropped, rd_valid<=0.
- No arithmetic besides ptr increment; ptr is AW bits wide and never exceeds DEPTH-1.

Optional Feature:
RAM_BANK_PARITY_EN
- Defined: each word stores WIDTH+1 bits, with even parity computed on write. The sweep writes parity 0. Extra ports: wr_par_flip input 1 (inverts the stored parity bit of this write, for fault injection) and rd_par_err output 1 (registered alongside rd_data; 1 when stored parity mismatches the data; 0 on reset, for out-of-range reads and bypassed reads unless flipped). On a bypassed read with wr_par_flip=1, rd_par_err=1.
- Undefined: no parity storage, no extra ports, identical timing.

Test Plan:
- Reset, DEPTH=8: release rst_n -> busy=1 for exactly 8 cycles, then 0; read every address -> 0 with rd_valid=1 one cycle after each rd_en.
- Write 0xBEEF to addr 3, read addr 3 next cycle -> rd_data=0xBEEF one cycle after rd_en; other addresses remain 0.
- Same-cycle wr_en/rd_en to addr 5 with data 0x1234 (old value 0xAAAA) -> rd_data=0x1234.
- DEPTH=6: write 0x7777 to addr 6 and 7, then read them -> rd_data=0, rd_valid=1; addr 0..5 unchanged.
- Fill all words with 0xFFFF, pulse clr at cycle t, and assert rd_en during the sweep -> busy cycles t+1..t+6 (DEPTH=6), rd_valid=0 throughout; afterwards all reads return 0. Assert rst_n low mid-sweep -> sweep restarts and lasts DEPTH full cycles.
- RAM_BANK_PARITY_EN: write 0x0003 to addr 2 with wr_par_flip=1, then read -> rd_par_err=1; rewrite without flip and read -> rd_par_err=0.
